// File: rtl/adder_tree_accumulator.sv
// Registered binary adder tree over 2**n_stage packed 2-bit signed products, followed by
// a saturating per-frame accumulator that reports one total per frame.
module adder_tree_accumulator #(
  parameter int n_stage   = 5,
  parameter int ACC_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2*(2**n_stage)-1:0]     mult_in,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic signed [n_stage+1:0]     sum_out,
  output logic                          sum_valid,
  output logic signed [ACC_WIDTH-1:0]   acc_out,
  output logic                          acc_valid,
  output logic                          acc_sat
);

  localparam int N = 2**n_stage;
  localparam int SW = n_stage + 2;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= n_stage; gi++) begin : g_lvl
      localparam int CNT = N >> gi;
      localparam int W   = gi + 2;
      logic [CNT*W-1:0] data;
      logic             valid;
      logic             last;

      if (gi == 0) begin : g_in
        assign data  = mult_in;
        assign valid = in_valid;
        assign last  = in_valid & in_last;
      end else begin : g_reg
        localparam int PW = W - 1;
        logic [CNT*W-1:0] sum_w, data_d, data_q;
        logic             valid_d, valid_q, last_d, last_q;

        // each pair is sign-extended by one bit, so the sum can never overflow
        for (gj = 0; gj < CNT; gj++) begin : g_add
          logic [PW-1:0] a, b;
          assign a = g_lvl[gi-1].data[(2*gj)*PW +: PW];
          assign b = g_lvl[gi-1].data[(2*gj+1)*PW +: PW];
          assign sum_w[gj*W +: W] = {a[PW-1], a} + {b[PW-1], b};
        end

        always_comb begin
          data_d  = data_q;
          valid_d = g_lvl[gi-1].valid;
          last_d  = g_lvl[gi-1].last;
          if (g_lvl[gi-1].valid) data_d = sum_w;
        end

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
          end
        end

        assign data  = data_q;
        assign valid = valid_q;
        assign last  = last_q;
      end
    end
  endgenerate

  logic [SW-1:0] tree_sum;
  logic          tree_valid, tree_last;
  assign tree_sum   = g_lvl[n_stage].data;
  assign tree_valid = g_lvl[n_stage].valid;
  assign tree_last  = g_lvl[n_stage].last;

  assign sum_out   = tree_sum;
  assign sum_valid = tree_valid;

  logic [ACC_WIDTH-1:0] acc_d, acc_q, acc_out_d, acc_out_q, nxt;
  logic                 sticky_d, sticky_q, acc_sat_d, acc_sat_q, acc_valid_d, acc_valid_q;
  logic [ACC_WIDTH:0]   raw;
  logic                 pos_ovf, neg_ovf, clamp_now;

  // one guard bit: overflow shows as disagreement between the two top bits
  assign raw = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-SW){tree_sum[SW-1]}}, tree_sum};
  assign pos_ovf   = ~raw[ACC_WIDTH] &  raw[ACC_WIDTH-1];
  assign neg_ovf   =  raw[ACC_WIDTH] & ~raw[ACC_WIDTH-1];
  assign clamp_now = pos_ovf | neg_ovf;

  always_comb begin
    nxt = raw[ACC_WIDTH-1:0];
    if (pos_ovf) nxt = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    if (neg_ovf) nxt = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  end

  always_comb begin
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    acc_out_d   = acc_out_q;
    acc_sat_d   = acc_sat_q;
    acc_valid_d = 1'b0;
    if (tree_valid) begin
      if (tree_last) begin
        acc_out_d   = nxt;
        acc_sat_d   = sticky_q | clamp_now;
        acc_valid_d = 1'b1;
        acc_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = nxt;
        sticky_d = sticky_q | clamp_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      acc_out_q   <= '0;
      acc_sat_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      acc_out_q   <= acc_out_d;
      acc_sat_q   <= acc_sat_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_sat   = acc_sat_q;
  assign acc_valid = acc_valid_q;

endmodule
